pokey_bank: RTL

Parametrised bus-and-audio front end for a bank of NCHIP POKEY sound/input chips; the next generation of the two-chip glue around the sound CPU's data bus. It registers the read-data mux across all chips, flags chip-select conflicts, and time-multiplexes a gain-weighted, saturating audio mix of every chip's output into one sample stream. POKEY instances stay outside; this block sits between them, the CPU data bus and the audio DAC path.

---
 rtl/pokey_bank_if.sv | 36 +++
 rtl/pokey_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pokey_bank_if.sv
// Bus, control and audio signals between the CPU side, the POKEY bank and the mixer output.
interface pokey_bank_if #(
    parameter int NCHIP = 2,
    parameter int OUT_W = 10
);
    logic [NCHIP-1:0]   cs_l;
    logic               rw_l;
    logic [7:0]         din;
    logic [8*NCHIP-1:0] chip_dout;
    logic [8*NCHIP-1:0] chip_audio;
    logic [7:0]         dout;
    logic               dout_oe;
    logic               any_sel;
    logic               bus_conflict;
    logic               ctrl_we;
    logic [3:0]         ctrl_addr;
    logic [3:0]         ctrl_data;
    logic               sample_tick;
    logic [OUT_W-1:0]   mix_out;
    logic               mix_valid;
    logic               mix_busy;
    logic               overrun;
    logic               clr_flags;

    modport master (
        output cs_l, rw_l, din, chip_dout, chip_audio, ctrl_we, ctrl_addr, ctrl_data,
               sample_tick, clr_flags,
        input  dout, dout_oe, any_sel, bus_conflict, mix_out, mix_valid, mix_busy, overrun
    );

    modport slave (
        input  cs_l, rw_l, din, chip_dout, chip_audio, ctrl_we, ctrl_addr, ctrl_data,
               sample_tick, clr_flags,
        output dout, dout_oe, any_sel, bus_conflict, mix_out, mix_valid, mix_busy, overrun
    );
endinterface

// File: rtl/pokey_bank.sv
// Read-data mux, chip-select conflict detection and sequential gain-weighted
// saturating audio mixer for a bank of NCHIP POKEY chips.
module pokey_bank #(
    parameter int NCHIP     = 2,
    parameter int OUT_W     = 10,
    parameter int MIX_SHIFT = 4,
    parameter int GAIN_RST  = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pokey_bank_if.slave   bus
);
    localparam int IDX_W  = (NCHIP > 1) ? $clog2(NCHIP) : 1;
    localparam int ACC_W  = 12 + $clog2(NCHIP) + 1;
    localparam int WIDE_W = ACC_W + OUT_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCHIP - 1);
    localparam logic [WIDE_W-1:0] SAT_MAX  = {{ACC_W{1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         dout_q;
    logic               dout_oe_q;
    logic               bus_conflict_q;
    logic               overrun_q;
    logic [3:0]         gain_q       [NCHIP];
    logic [7:0]         snap_audio_q [NCHIP];
    logic [3:0]         snap_gain_q  [NCHIP];
    logic [IDX_W-1:0]   idx_q;
    logic [ACC_W-1:0]   acc_q;
    logic [OUT_W-1:0]   mix_out_q;
    logic               mix_valid_q;

    logic [7:0]         rd_data_s;
    logic [4:0]         sel_cnt_s;
    logic               any_sel_s;
    logic               conflict_s;
    logic               snap_en_s;
    logic               acc_en_s;
    logic               done_s;
    logic               overrun_set_s;
    logic [11:0]        prod_s;
    logic [WIDE_W-1:0]  shifted_s;
    logic [OUT_W-1:0]   sat_s;

    // Read mux priority (descending scan so the lowest selected index wins) and select count
    always_comb begin
        rd_data_s = bus.din;
        sel_cnt_s = 5'd0;
        for (int i = NCHIP - 1; i >= 0; i--) begin
            rd_data_s = bus.cs_l[i] ? rd_data_s : bus.chip_dout[8*i +: 8];
            sel_cnt_s = sel_cnt_s + {4'd0, ~bus.cs_l[i]};
        end
        any_sel_s  = (sel_cnt_s != 5'd0);
        conflict_s = (sel_cnt_s > 5'd1);
    end

    // Registered CPU read path and sticky conflict flag (set wins over clear)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q         <= 8'd0;
            dout_oe_q      <= 1'b0;
            bus_conflict_q <= 1'b0;
        end else begin
            dout_q         <= rd_data_s;
            dout_oe_q      <= any_sel_s & bus.rw_l;
            bus_conflict_q <= conflict_s ? 1'b1 : (bus.clr_flags ? 1'b0 : bus_conflict_q);
        end
    end

    // Per-chip gain registers; indices beyond the bank match no register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCHIP; i++) gain_q[i] <= 4'(GAIN_RST);
        end else begin
            for (int i = 0; i < NCHIP; i++) begin
                if (bus.ctrl_we && (bus.ctrl_addr == 4'(i))) gain_q[i] <= bus.ctrl_data;
            end
        end
    end

    // Mixer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Mixer next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = bus.sample_tick ? ST_ACC : ST_IDLE;
            ST_ACC:  state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_ACC;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Mixer control decode; a tick outside IDLE is dropped and flagged
    always_comb begin
        snap_en_s     = 1'b0;
        acc_en_s      = 1'b0;
        done_s        = 1'b0;
        overrun_set_s = 1'b0;
        case (state_q)
            ST_IDLE: snap_en_s = bus.sample_tick;
            ST_ACC: begin
                acc_en_s      = 1'b1;
                overrun_set_s = bus.sample_tick;
            end
            ST_DONE: begin
                done_s        = 1'b1;
                overrun_set_s = bus.sample_tick;
            end
            default: snap_en_s = 1'b0;
        endcase
    end

    // One channel product per cycle; scaled sum clamps at full scale
    always_comb begin
        prod_s    = {4'd0, snap_audio_q[idx_q]} * {8'd0, snap_gain_q[idx_q]};
        shifted_s = {{OUT_W{1'b0}}, acc_q} >> MIX_SHIFT;
        sat_s     = (shifted_s > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : shifted_s[OUT_W-1:0];
    end

    // Mixer datapath: snapshot at tick, accumulate, publish, sticky overrun
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCHIP; i++) begin
                snap_audio_q[i] <= 8'd0;
                snap_gain_q[i]  <= 4'd0;
            end
            idx_q       <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mix_valid_q <= done_s;
            overrun_q   <= overrun_set_s ? 1'b1 : (bus.clr_flags ? 1'b0 : overrun_q);
            if (snap_en_s) begin
                for (int i = 0; i < NCHIP; i++) begin
                    snap_audio_q[i] <= bus.chip_audio[8*i +: 8];
                    snap_gain_q[i]  <= gain_q[i];
                end
                acc_q <= '0;
                idx_q <= '0;
            end else if (acc_en_s) begin
                acc_q <= acc_q + {{(ACC_W-12){1'b0}}, prod_s};
                idx_q <= idx_q + IDX_W'(1);
            end
            if (done_s) mix_out_q <= sat_s;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.dout_oe      = dout_oe_q;
    assign bus.any_sel      = any_sel_s;
    assign bus.bus_conflict = bus_conflict_q;
    assign bus.mix_out      = mix_out_q;
    assign bus.mix_valid    = mix_valid_q;
    assign bus.mix_busy     = (state_q != ST_IDLE);
    assign bus.overrun      = overrun_q;
endmodule
